// File: rtl/alu_pipe_if.sv
// Operand/result valid-ready bundle for alu_pipe.
// master = operand source and result consumer, slave = the ALU.
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] C;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output in_valid, op_code, A, B, out_ready,
    input  in_ready, out_valid, C, overflow, zero, negative
  );

  modport slave (
    input  in_valid, op_code, A, B, out_ready,
    output in_ready, out_valid, C, overflow, zero, negative
  );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined signed ALU with valid/ready handshake, flags and saturating overflow counter.
// Define ALU_SAT_EN to turn opcodes 110/111 into clamping ADDS/SUBS.
module alu_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  alu_pipe_if.slave        bus,
  input  logic             clr_count,
  output logic [CNT_W-1:0] ovf_count
);

  typedef struct packed {
    logic [WIDTH-1:0] c;
    logic             ovf;
    logic             zero;
    logic             neg;
  } res_t;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             sub_ovf;
  logic             a_lt_b;
  res_t             alu_res;

  res_t             stage_q [STAGES];
  res_t             stage_d [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             stall;

  always_comb begin
    sum     = bus.A + bus.B;
    diff    = bus.A - bus.B;
    add_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1]  != bus.A[WIDTH-1]);
    sub_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
    a_lt_b  = $signed(bus.A) < $signed(bus.B);
    // NOTE: every field gets a default up front so no path through the case infers a latch.
    alu_res = '0;
    case (bus.op_code)
      3'b000: alu_res.c = bus.A | bus.B;
      3'b001: alu_res.c = bus.A & bus.B;
      3'b010: begin alu_res.c = sum;  alu_res.ovf = add_ovf; end
      3'b011: begin alu_res.c = diff; alu_res.ovf = sub_ovf; end
      3'b100: alu_res.c = bus.A ^ bus.B;
      3'b101: alu_res.c = {{(WIDTH-1){1'b0}}, a_lt_b};
`ifdef ALU_SAT_EN
      // Overflow direction always follows the sign of A.
      3'b110: begin
        alu_res.c   = add_ovf ? (bus.A[WIDTH-1] ? MIN_NEG : MAX_POS) : sum;
        alu_res.ovf = add_ovf;
      end
      default: begin
        alu_res.c   = sub_ovf ? (bus.A[WIDTH-1] ? MIN_NEG : MAX_POS) : diff;
        alu_res.ovf = sub_ovf;
      end
`else
      3'b110:  begin alu_res.c = sum;  alu_res.ovf = add_ovf; end
      default: begin alu_res.c = diff; alu_res.ovf = sub_ovf; end
`endif
    endcase
    alu_res.zero = (alu_res.c == '0);
    alu_res.neg  = alu_res.c[WIDTH-1];
  end

  assign stall        = valid_q[STAGES-1] && !bus.out_ready;
  assign bus.in_ready = !stall;

  always_comb begin
    stage_d = stage_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    // Bubbles advance too, so a free slot never blocks the stage behind it.
    if (!stall) begin
      stage_d[0] = alu_res;
      valid_d[0] = bus.in_valid;
      for (int i = 1; i < STAGES; i++) begin
        stage_d[i] = stage_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
    end
    if (clr_count) begin
      cnt_d = '0;
    end else if (valid_q[STAGES-1] && bus.out_ready && stage_q[STAGES-1].ovf && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the pipeline data is reset as well, since C and its flags must read zero out of reset.
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.C         = stage_q[STAGES-1].c;
  assign bus.overflow  = stage_q[STAGES-1].ovf;
  assign bus.zero      = stage_q[STAGES-1].zero;
  assign bus.negative  = stage_q[STAGES-1].neg;
  assign ovf_count     = cnt_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe at WIDTH=8, STAGES=2, CNT_W=2.
// Expected values are hand-computed; opcode 110/111 expectations follow ALU_SAT_EN.
`timescale 1ns/1ps
module tb_alu_pipe;
  localparam int WIDTH  = 8;
  localparam int STAGES = 2;
  localparam int CNT_W  = 2;

  localparam logic [2:0] OP_OR  = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_ADS = 3'b110;
  localparam logic [2:0] OP_SBS = 3'b111;

  logic             clk = 1'b0;
  logic             reset;
  logic             clr_count;
  logic [CNT_W-1:0] ovf_count;
  int               checks = 0;
  int               errors = 0;

  alu_pipe_if #(.WIDTH(WIDTH)) bus ();

  alu_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .clr_count (clr_count),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  // Issue one op with an empty pipe and out_ready=1; return at the first negedge showing out_valid.
  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] c, output logic ovf, output logic z,
                       output logic n, output bit got);
    got = 1'b0; c = 'x; ovf = 1'bx; z = 1'bx; n = 1'bx;
    @(negedge clk);
    bus.op_code = op; bus.A = a; bus.B = b; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.out_valid === 1'b1) begin
        c = bus.C; ovf = bus.overflow; z = bus.zero; n = bus.negative; got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; clr_count = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.op_code = '0; bus.A = '0; bus.B = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.out_valid, bus.C, bus.overflow, bus.zero, bus.negative, ovf_count} !== '0)
      $display("FAIL reset_state: got valid=%b C=%h ovf=%b z=%b n=%b cnt=%0d expected all zero",
               bus.out_valid, bus.C, bus.overflow, bus.zero, bus.negative, ovf_count);
    if ({bus.out_valid, bus.C, bus.overflow, bus.zero, bus.negative, ovf_count} !== '0) errors++;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_add_latency();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.op_code = OP_ADD; bus.A = 8'd100; bus.B = 8'd50; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL add_early_valid: got %b expected 0", bus.out_valid);
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.out_valid, bus.C, bus.overflow, bus.zero, bus.negative} !== {1'b1, 8'h96, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL add_result: got valid=%b C=%h ovf=%b z=%b n=%b expected valid=1 C=96 ovf=1 z=0 n=1",
               bus.out_valid, bus.C, bus.overflow, bus.zero, bus.negative);
    end
  endtask

  task automatic test_sub();
    logic [7:0] c; logic ovf, z, n; bit got;
    do_op(OP_SUB, 8'h80, 8'h01, c, ovf, z, n, got);
    checks++;
    if (!got || {c, ovf, z, n} !== {8'h7F, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sub_min_minus_one: got=%b C=%h ovf=%b z=%b n=%b expected C=7f ovf=1 z=0 n=0",
                         got, c, ovf, z, n);
    end
    do_op(OP_SUB, 8'd5, 8'd5, c, ovf, z, n, got);
    checks++;
    if (!got || {c, ovf, z, n} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sub_equal: got=%b C=%h ovf=%b z=%b n=%b expected C=00 ovf=0 z=1 n=0",
                         got, c, ovf, z, n);
    end
  endtask

  task automatic test_logic();
    logic [2:0] ops [7] = '{OP_OR, OP_AND, OP_XOR, OP_SLT, OP_SLT, OP_SLT, OP_ADD};
    logic [7:0] as  [7] = '{8'h0F, 8'h0F, 8'h55, 8'hFD, 8'h02, 8'h80, 8'hF6};
    logic [7:0] bs  [7] = '{8'hF0, 8'hF0, 8'hFF, 8'h02, 8'hFD, 8'h7F, 8'hF6};
    logic [7:0] ec  [7] = '{8'hFF, 8'h00, 8'hAA, 8'h01, 8'h00, 8'h01, 8'hEC};
    logic       ez  [7] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
    logic [7:0] c; logic ovf, z, n; bit got;
    for (int i = 0; i < 7; i++) begin
      do_op(ops[i], as[i], bs[i], c, ovf, z, n, got);
      checks++;
      if (!got || {c, ovf, z, n} !== {ec[i], 1'b0, ez[i], ec[i][7]}) begin
        errors++;
        $display("FAIL logic_vec%0d: got=%b C=%h ovf=%b z=%b n=%b expected C=%h ovf=0 z=%b n=%b",
                 i, got, c, ovf, z, n, ec[i], ez[i], ec[i][7]);
      end
    end
  endtask

  task automatic test_sat();
    logic [7:0] c; logic ovf, z, n; bit got;
    logic [7:0] exp_adds, exp_subs;
`ifdef ALU_SAT_EN
    exp_adds = 8'h7F; exp_subs = 8'h80;
`else
    exp_adds = 8'h96; exp_subs = 8'h7F;
`endif
    do_op(OP_ADS, 8'd100, 8'd50, c, ovf, z, n, got);
    checks++;
    if (!got || {c, ovf, z, n} !== {exp_adds, 1'b1, 1'b0, exp_adds[7]}) begin
      errors++; $display("FAIL adds_overflow: got=%b C=%h ovf=%b z=%b n=%b expected C=%h ovf=1",
                         got, c, ovf, z, n, exp_adds);
    end
    do_op(OP_SBS, 8'h80, 8'h01, c, ovf, z, n, got);
    checks++;
    if (!got || {c, ovf, z, n} !== {exp_subs, 1'b1, 1'b0, exp_subs[7]}) begin
      errors++; $display("FAIL subs_overflow: got=%b C=%h ovf=%b z=%b n=%b expected C=%h ovf=1",
                         got, c, ovf, z, n, exp_subs);
    end
    do_op(OP_ADS, 8'd3, 8'd4, c, ovf, z, n, got);
    checks++;
    if (!got || {c, ovf, z, n} !== {8'h07, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL adds_plain: got=%b C=%h ovf=%b expected C=07 ovf=0", got, c, ovf);
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] ops [4] = '{OP_ADD, OP_ADD, OP_SUB, OP_XOR};
    logic [7:0] as  [4] = '{8'd1, 8'd2, 8'd10, 8'h0F};
    logic [7:0] bs  [4] = '{8'd1, 8'd3, 8'd4,  8'h01};
    logic [7:0] ec  [4] = '{8'd2, 8'd5, 8'd6,  8'h0E};
    int k = 0;
    int n = 0;
    bit hv = 1'b0;
    logic [7:0] hc = '0;
    for (int cyc = 0; cyc < 30 && n < 4; cyc++) begin
      @(negedge clk);
      bus.out_ready = (cyc >= 5);
      if (k < 4) begin
        bus.op_code = ops[k]; bus.A = as[k]; bus.B = bs[k]; bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          errors++; $display("FAIL bp_in_ready cyc%0d: got %b expected 0", cyc, bus.in_ready);
        end
        if (hv) begin
          checks++;
          if (bus.C !== hc) begin
            errors++; $display("FAIL bp_hold cyc%0d: got C=%h expected %h", cyc, bus.C, hc);
          end
        end
        hv = 1'b1; hc = bus.C;
      end else begin
        hv = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (bus.C !== ec[n]) begin
          errors++; $display("FAIL bp_order%0d: got C=%h expected %h", n, bus.C, ec[n]);
        end
        n++;
      end
      if (bus.in_valid && bus.in_ready) k++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL bp_count: got %0d results expected 4", n);
    end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_extra: got out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_counter();
    logic [7:0] c; logic ovf, z, n; bit got;
    int missing = 0;
    bus.out_ready = 1'b1;
    @(negedge clk); clr_count = 1'b1;
    @(negedge clk); clr_count = 1'b0;
    #1;
    checks++;
    if (ovf_count !== 2'd0) begin
      errors++; $display("FAIL cnt_clear: got %0d expected 0", ovf_count);
    end
    for (int i = 0; i < 5; i++) begin
      do_op(OP_ADD, 8'd100, 8'd50, c, ovf, z, n, got);
      if (!got) missing++;
      if (i == 1) begin
        checks++;
        if (ovf_count !== 2'd1) begin
          errors++; $display("FAIL cnt_one: got %0d expected 1", ovf_count);
        end
      end
    end
    @(negedge clk); #1;
    checks++;
    if (missing != 0 || ovf_count !== 2'd3) begin
      errors++; $display("FAIL cnt_saturate: got %0d (missing %0d) expected 3", ovf_count, missing);
    end
    do_op(OP_ADD, 8'd100, 8'd50, c, ovf, z, n, got);
    clr_count = 1'b1;
    @(negedge clk);
    clr_count = 1'b0;
    #1;
    checks++;
    if (!got || ovf_count !== 2'd0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL cnt_clear_wins: got cnt=%0d valid=%b delivered=%b expected cnt=0 valid=0",
                         ovf_count, bus.out_valid, got);
    end
  endtask

  task automatic test_reset_midflight();
    logic [7:0] c; logic ovf, z, n; bit got;
    bit seen = 1'b0;
    bus.out_ready = 1'b1;
    do_op(OP_ADD, 8'd100, 8'd50, c, ovf, z, n, got);
    @(negedge clk); #1;
    checks++;
    if (!got || ovf_count !== 2'd1) begin
      errors++; $display("FAIL rst_precount: got %0d expected 1", ovf_count);
    end
    @(negedge clk);
    bus.op_code = OP_ADD; bus.A = 8'd100; bus.B = 8'd50; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.op_code = OP_SUB; bus.A = 8'h80; bus.B = 8'h01;
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.C, bus.overflow, bus.zero, bus.negative, ovf_count} !== '0) begin
      errors++; $display("FAIL rst_flush: got valid=%b C=%h ovf=%b cnt=%0d expected all zero",
                         bus.out_valid, bus.C, bus.overflow, ovf_count);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_no_delivery: got seen=%b in_ready=%b expected seen=0 in_ready=1",
                         seen, bus.in_ready);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_add_latency();
    test_sub();
    test_logic();
    test_sat();
    test_backpressure();
    test_counter();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
